// File: rtl/wave_meter_if.sv
// Sample-stream bundle for wave_meter: strobe/clear/sample in, measurements out.
// The master side drives samples; the slave side is the meter itself.
interface wave_meter_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int P_WIDTH = 16
);
    logic               en;
    logic               clear;
    logic [D_WIDTH-1:0] din;
    logic [P_WIDTH-1:0] period;
    logic [D_WIDTH-1:0] pmax;
    logic [D_WIDTH-1:0] pmin;
    logic [A_WIDTH-1:0] incr_est;
    logic               meas_valid;
    logic               locked;
    logic               timeout;

    modport master (
        output en, clear, din,
        input  period, pmax, pmin, incr_est, meas_valid, locked, timeout
    );

    modport slave (
        input  en, clear, din,
        output period, pmax, pmin, incr_est, meas_valid, locked, timeout
    );
endinterface

// File: rtl/wave_meter.sv
// Period / peak / trough meter for offset-binary waveforms, with a restoring
// divider that turns the measured period into a phase-increment estimate.
module wave_meter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int P_WIDTH = 16,
    parameter int HYST    = 8
) (
    input  logic        clk,
    input  logic        rst,
    wave_meter_if.slave bus
);
    localparam int MID = 2 ** (D_WIDTH - 1);
    localparam logic [D_WIDTH:0]   HI_TH       = (D_WIDTH + 1)'(MID + HYST);
    localparam logic [D_WIDTH:0]   LO_TH       = (D_WIDTH + 1)'(MID - HYST);
    localparam logic [P_WIDTH-1:0] CNT_PRE_SAT = {{(P_WIDTH - 1){1'b1}}, 1'b0};
    localparam int                 IW          = $clog2(A_WIDTH + 1);
    localparam logic [IW-1:0]      ITER_LAST   = IW'(A_WIDTH);

    typedef enum logic {
        ACQUIRE,
        MEASURE
    } ctl_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    ctl_state_t ctl_state, ctl_next;
    div_state_t div_state, div_next;

    logic [D_WIDTH:0]   din_ext;
    logic               cmp_high;
    logic               rise;
    logic               fall;

    logic               win_restart;
    logic               win_update;
    logic               stage_load;
    logic               sat_hit;

    logic [P_WIDTH-1:0] cnt;
    logic [D_WIDTH-1:0] win_max;
    logic [D_WIDTH-1:0] win_min;

    logic [P_WIDTH-1:0] stage_period;
    logic [D_WIDTH-1:0] stage_max;
    logic [D_WIDTH-1:0] stage_min;
    logic [P_WIDTH-1:0] rem;
    logic [A_WIDTH:0]   quo;
    logic [IW-1:0]      div_iter;
    logic [P_WIDTH:0]   trial;
    logic [P_WIDTH:0]   diff;
    logic               fits;

    // Hysteresis comparator; only enabled samples may move it.
    assign din_ext = {1'b0, bus.din};
    assign rise    = bus.en && !cmp_high && (din_ext >= HI_TH);
    assign fall    = bus.en &&  cmp_high && (din_ext <= LO_TH);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_high <= 1'b0;
        end else if (bus.clear) begin
            cmp_high <= 1'b0;
        end else if (rise) begin
            cmp_high <= 1'b1;
        end else if (fall) begin
            cmp_high <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_state <= ACQUIRE;
            div_state <= DIV_IDLE;
        end else if (bus.clear) begin
            ctl_state <= ACQUIRE;
            div_state <= DIV_IDLE;
        end else begin
            ctl_state <= ctl_next;
            div_state <= div_next;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        ctl_next    = ctl_state;
        win_restart = 1'b0;
        win_update  = 1'b0;
        stage_load  = 1'b0;
        sat_hit     = 1'b0;
        case (ctl_state)
            ACQUIRE: begin
                if (rise) begin
                    win_restart = 1'b1;
                    ctl_next    = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    win_restart = 1'b1;
                    // A crossing that lands while the divider iterates is dropped.
                    stage_load  = (div_state != DIV_RUN);
                end else if (bus.en) begin
                    if (cnt == CNT_PRE_SAT) begin
                        sat_hit  = 1'b1;
                        ctl_next = ACQUIRE;
                    end else begin
                        win_update = 1'b1;
                    end
                end
            end
            default: ctl_next = ACQUIRE;
        endcase
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (stage_load) div_next = DIV_RUN;
            DIV_RUN:  if (div_iter == ITER_LAST) div_next = DIV_DONE;
            DIV_DONE: div_next = stage_load ? DIV_RUN : DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    // Dividend is 2^A_WIDTH: only the first shifted-in bit is a one.
    always_comb begin
        trial = {rem, (div_iter == '0)};
        diff  = trial - {1'b0, stage_period};
        fits  = (trial >= {1'b0, stage_period});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            win_max <= '0;
            win_min <= '0;
        end else if (bus.clear) begin
            cnt     <= '0;
            win_max <= '0;
            win_min <= '0;
        end else if (win_restart) begin
            cnt     <= '0;
            win_max <= bus.din;
            win_min <= bus.din;
        end else if (win_update) begin
            cnt <= cnt + P_WIDTH'(1);
            if (bus.din > win_max) win_max <= bus.din;
            if (bus.din < win_min) win_min <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_period <= '0;
            stage_max    <= '0;
            stage_min    <= '0;
            rem          <= '0;
            quo          <= '0;
            div_iter     <= '0;
        end else if (bus.clear) begin
            stage_period <= '0;
            stage_max    <= '0;
            stage_min    <= '0;
            rem          <= '0;
            quo          <= '0;
            div_iter     <= '0;
        end else if (stage_load) begin
            stage_period <= cnt + P_WIDTH'(1);
            stage_max    <= win_max;
            stage_min    <= win_min;
            rem          <= '0;
            quo          <= '0;
            div_iter     <= '0;
        end else if (div_state == DIV_RUN) begin
            rem      <= fits ? diff[P_WIDTH-1:0] : trial[P_WIDTH-1:0];
            quo      <= {quo[A_WIDTH-1:0], fits};
            div_iter <= div_iter + IW'(1);
        end
    end

    // Completion publishes the staged window; staging may be reloaded on the
    // same edge by a new crossing without disturbing what is published.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.period     <= '0;
            bus.pmax       <= '0;
            bus.pmin       <= '0;
            bus.incr_est   <= '0;
            bus.meas_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.timeout    <= 1'b0;
        end else if (bus.clear) begin
            bus.period     <= '0;
            bus.pmax       <= '0;
            bus.pmin       <= '0;
            bus.incr_est   <= '0;
            bus.meas_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            bus.meas_valid <= 1'b0;
            bus.timeout    <= sat_hit;
            if (div_state == DIV_DONE) begin
                bus.period     <= stage_period;
                bus.pmax       <= stage_max;
                bus.pmin       <= stage_min;
                bus.incr_est   <= quo[A_WIDTH] ? '1 : quo[A_WIDTH-1:0];
                bus.meas_valid <= 1'b1;
            end
            if (sat_hit) begin
                bus.locked <= 1'b0;
            end else if (div_state == DIV_DONE) begin
                bus.locked <= 1'b1;
            end
        end
    end
endmodule
